// File: rtl/elevator_ctrl.sv
// elevator_ctrl: car-level control FSM. Latches floor calls, chooses a
// travel direction, steps the car one floor per timer period and holds the
// door open for one timer period.
// Ports:
//   i_clock       system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_req         floor-call pulses, one bit per floor
//   i_timer_done  expiry from the downstream timer
//   o_timer_en    enable to the downstream timer
//   o_floor       current car floor
//   o_up/o_down   car moving up / down
//   o_door_open   door open
//   o_pending     latched outstanding requests
module elevator_ctrl #(
  parameter int unsigned pFLOORS     = 4,
  parameter int unsigned pFLOOR_BITS = 2
) (
  input  logic                   i_clock,
  input  logic                   i_rst_n,
  input  logic [pFLOORS-1:0]     i_req,
  input  logic                   i_timer_done,
  output logic                   o_timer_en,
  output logic [pFLOOR_BITS-1:0] o_floor,
  output logic                   o_up,
  output logic                   o_down,
  output logic                   o_door_open,
  output logic [pFLOORS-1:0]     o_pending
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR_OPEN = 2'd3;

  localparam logic [pFLOOR_BITS-1:0] TOP_FLOOR = pFLOOR_BITS'(pFLOORS - 1);
  localparam logic [pFLOOR_BITS-1:0] ONE_FLOOR = pFLOOR_BITS'(1);

  logic [1:0]             state, state_n;
  logic [pFLOOR_BITS-1:0] floor_n;
  logic [pFLOORS-1:0]     pending_n;
  logic                   last_up, last_up_n;
  logic                   restart, restart_n;

  logic [pFLOORS-1:0]     req_c;
  logic                   above_c, below_c, done_c;

  // Requests seen this cycle count as already latched for every decision.
  assign req_c  = o_pending | i_req;
  // A done is only meaningful while timing and outside the restart cycle.
  assign done_c = i_timer_done && !restart && (state != IDLE);

  // Outstanding calls strictly above / below the car.
  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    for (int unsigned f = 0; f < pFLOORS; f++) begin
      if (req_c[f]) begin
        if (f > 32'(o_floor)) above_c = 1'b1;
        if (f < 32'(o_floor)) below_c = 1'b1;
      end
    end
  end

  // Next-state, floor, direction memory, request latch and restart flag.
  always_comb begin
    state_n   = state;
    floor_n   = o_floor;
    last_up_n = last_up;
    case (state)
      IDLE: begin
        if (req_c[o_floor]) begin
          state_n = DOOR_OPEN;
        end else if (above_c && (!below_c || last_up)) begin
          state_n   = MOVE_UP;
          last_up_n = 1'b1;
        end else if (below_c) begin
          state_n   = MOVE_DOWN;
          last_up_n = 1'b0;
        end
      end
      MOVE_UP: begin
        if (o_floor == TOP_FLOOR) begin
          state_n = DOOR_OPEN;
        end else if (done_c) begin
          floor_n = o_floor + ONE_FLOOR;
          state_n = req_c[floor_n] ? DOOR_OPEN : MOVE_UP;
        end
      end
      MOVE_DOWN: begin
        if (o_floor == '0) begin
          state_n = DOOR_OPEN;
        end else if (done_c) begin
          floor_n = o_floor - ONE_FLOOR;
          state_n = req_c[floor_n] ? DOOR_OPEN : MOVE_DOWN;
        end
      end
      DOOR_OPEN: begin
        if (done_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Calls for the floor the door is open at are served, not latched.
    pending_n = req_c;
    if (state_n == DOOR_OPEN) pending_n[floor_n] = 1'b0;

    // One idle timer cycle clears the count before each new period.
    restart_n = done_c || ((state_n != state) && (state_n != IDLE));
  end

  // State registers.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      o_floor   <= '0;
      o_pending <= '0;
      last_up   <= 1'b1;
      restart   <= 1'b0;
    end else begin
      state     <= state_n;
      o_floor   <= floor_n;
      o_pending <= pending_n;
      last_up   <= last_up_n;
      restart   <= restart_n;
    end
  end

  // Decodes of registered state only.
  assign o_up        = (state == MOVE_UP);
  assign o_down      = (state == MOVE_DOWN);
  assign o_door_open = (state == DOOR_OPEN);
  assign o_timer_en  = (state != IDLE) && !restart;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: drives elevator_ctrl with directed and random floor
// calls, closes the loop through a 3-cycle timer, and compares every output
// each cycle against a cycle-counting reference of the car's behaviour.
module tb_elevator_ctrl;

  localparam int unsigned NF = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       timer_done;
  logic       timer_en;
  logic [1:0] floor;
  logic       up, down, door;
  logic [3:0] pending;
  logic       force_done;

  int n_checks = 0;
  int n_pass   = 0;

  elevator_ctrl #(.pFLOORS(4), .pFLOOR_BITS(2)) dut (
    .i_clock      (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_timer_done (timer_done),
    .o_timer_en   (timer_en),
    .o_floor      (floor),
    .o_up         (up),
    .o_down       (down),
    .o_door_open  (door),
    .o_pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer with 2-bit count: clears while disabled, done on the 3rd enabled cycle.
  logic [1:0] tcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             tcnt <= 2'd0;
    else if (!timer_en)     tcnt <= 2'd0;
    else if (tcnt == 2'd2)  tcnt <= 2'd0;
    else                    tcnt <= tcnt + 2'd1;
  end
  assign timer_done = (timer_en && tcnt == 2'd2) || force_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: mode 0 idle, 1 up, 2 down, 3 door; age counts cycles in the
  // current period (age 0 is the timer-clear cycle, period ends at age 3).
  int m_mode, m_floor, m_age;
  bit m_lastup;
  bit m_pend[NF];

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int f = 0; f < NF; f++) v[f] = m_pend[f];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_floor = 0; m_age = 0; m_lastup = 1;
      for (int f = 0; f < NF; f++) m_pend[f] = 0;
    end else begin
      bit r[NF];
      bit any_up, any_dn;
      int nmode, nfloor, nage;
      for (int f = 0; f < NF; f++) r[f] = m_pend[f] | req[f];
      nmode = m_mode; nfloor = m_floor; nage = m_age + 1;
      if (m_mode == 0) begin
        nage = 0;
        any_up = 0; any_dn = 0;
        for (int f = 0; f < NF; f++) begin
          if (r[f] && f > m_floor) any_up = 1;
          if (r[f] && f < m_floor) any_dn = 1;
        end
        if (r[m_floor]) nmode = 3;
        else if (any_up && (!any_dn || m_lastup)) begin nmode = 1; m_lastup = 1; end
        else if (any_dn) begin nmode = 2; m_lastup = 0; end
      end else if (m_age == 3) begin
        nage = 0;
        if (m_mode == 3) nmode = 0;
        else begin
          nfloor = (m_mode == 1) ? m_floor + 1 : m_floor - 1;
          nmode  = r[nfloor] ? 3 : m_mode;
        end
      end
      for (int f = 0; f < NF; f++) m_pend[f] = r[f];
      if (nmode == 3) m_pend[nfloor] = 0;
      m_mode = nmode; m_floor = nfloor; m_age = nage;
    end
  end

  logic done_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= timer_done;
  end

  // Per-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("floor",    32'(floor),    32'(m_floor));
      chk("up",       32'(up),       32'(m_mode == 1));
      chk("down",     32'(down),     32'(m_mode == 2));
      chk("door",     32'(door),     32'(m_mode == 3));
      chk("pending",  32'(pending),  32'(m_pend_vec()));
      chk("timer_en", 32'(timer_en), 32'(m_mode != 0 && m_age != 0));
      if (done_q) chk("en_after_done", 32'(timer_en), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] v);
    req = v;
    step();
    req = 4'd0;
  endtask

  task automatic wait_door(input int f);
    int n = 0;
    while (!(door && floor == 2'(f)) && n < 60) begin step(); n++; end
    chk($sformatf("reach_door_%0d", f), 32'(door && floor == 2'(f)), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((up || down || door) && n < 60) begin step(); n++; end
    chk("reach_idle", 32'(up || down || door), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'd0; force_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_floor",   32'(floor),   32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_outs",    32'({timer_en, up, down, door}), 32'd0);

    // Travel 0 -> 2, four cycles per floor, then door, then idle.
    pulse_req(4'b0100);
    chk("t1_up",      32'(up),      32'd1);
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_en",      32'(timer_en), 32'd0);
    repeat (4) step();
    chk("t1_floor1",  32'(floor),   32'd1);
    repeat (4) step();
    chk("t1_floor2",  32'(floor),   32'd2);
    chk("t1_door",    32'(door),    32'd1);
    chk("t1_pend0",   32'(pending), 32'd0);
    repeat (4) step();
    chk("t1_idle",    32'({timer_en, up, down, door, pending}), 32'd0);
    chk("t1_idle_fl", 32'(floor),   32'd2);

    // Same-floor call in idle opens the door on the next edge.
    pulse_req(4'b0100);
    chk("t2_door",    32'({up, down, door}), 32'b001);
    chk("t2_pending", 32'(pending), 32'd0);
    wait_idle();

    // Go down to 0, then up to 1 so the last direction is up.
    pulse_req(4'b0001);
    wait_door(0);
    wait_idle();
    pulse_req(4'b0010);
    wait_door(1);
    wait_idle();

    // Calls on both sides: last direction (up) wins.
    pulse_req(4'b1001);
    chk("t3_pref_up", 32'({up, down}), 32'b10);
    wait_door(3);
    req = 4'b1000;
    repeat (3) step();
    req = 4'd0;
    chk("t4_absorb",  32'(pending), 32'h1);
    wait_idle();
    step();
    chk("t3_then_down", 32'(down), 32'd1);
    wait_door(0);
    chk("t3_pend0",   32'(pending), 32'd0);
    wait_idle();
    chk("t4_idle_pend", 32'(pending), 32'd0);

    // Forced done while idle changes nothing.
    force_done = 1'b1;
    repeat (4) step();
    force_done = 1'b0;
    chk("t5_floor",  32'(floor), 32'd0);
    chk("t5_state",  32'({up, down, door}), 32'd0);
    step();
    chk("t5_still",  32'({timer_en, up, down, door}), 32'd0);

    // Reset in the middle of a downward move.
    pulse_req(4'b1000);
    wait_door(3);
    wait_idle();
    pulse_req(4'b0001);
    chk("t6_down",    32'(down), 32'd1);
    step(); step();
    chk("t6_pending", 32'(pending), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_floor", 32'(floor),    32'd0);
    chk("t6_rst_pend",  32'(pending),  32'd0);
    chk("t6_rst_en",    32'(timer_en), 32'd0);
    chk("t6_rst_down",  32'(down),     32'd0);
    step();
    rst_n = 1'b1;

    // Random calls, with rare mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
      else                           req = 4'd0;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    req = 4'd0;
    repeat (60) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Car-level control FSM for the elevator project.
- Latches floor-call requests and picks a travel direction.
- Steps the car floor by floor and holds the door open.
- Sits directly upstream of the timer block: drives the timer's i_enable through o_timer_en and consumes its o_done on i_timer_done. One timer period is the floor-to-floor travel time, and also the door-open time.

Parameters:
- pFLOORS, 4, number of floors served, numbered 0..pFLOORS-1; legal range 2..16.
- pFLOOR_BITS, 2, width of the floor index; must satisfy 2^pFLOOR_BITS >= pFLOORS.

Ports:
- i_clock  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  pFLOORS  floor-call requests, one bit per floor; a one-cycle pulse is enough.
- i_timer_done  input  1  timer expiry, connected to the timer o_done.
- o_timer_en  output  1  timer enable, connected to the timer i_enable.
- o_floor  output  pFLOOR_BITS  current car floor.
- o_up  output  1  car moving up.
- o_down  output  1  car moving down.
- o_door_open  output  1  door open.
- o_pending  output  pFLOORS  latched outstanding requests.

Behaviour:
- Interface: one clock, i_clock. Reset i_rst_n is asynchronous, active-low.
- Reset values: state IDLE, o_floor=0, o_pending=0, last direction=UP, restart flag=0. All 1-bit outputs are 0.
- Request latch:
  - Every cycle, pending <= pending | i_req.
  - Exception: the bit for o_floor is cleared when the FSM enters DOOR_OPEN, and stays cleared while in DOOR_OPEN; a same-floor call during door-open is absorbed.
  - All next-state decisions use the combined vector req_c = pending | i_req, so a same-cycle request is honoured.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE:
  - If req_c[o_floor] is set, go to DOOR_OPEN.
  - Else if requests exist both above and below, keep the last direction.
  - Else move toward whichever side has requests: above gives MOVE_UP, below gives MOVE_DOWN.
  - With no requests, stay in IDLE.
  - The chosen direction is stored as the last direction.
- MOVE_UP, on i_timer_done:
  - o_floor <= o_floor+1.
  - If req_c[o_floor+1] is set, go to DOOR_OPEN; else stay in MOVE_UP.
  - Without done, hold.
- MOVE_DOWN: mirror image of MOVE_UP, with o_floor-1.
- DOOR_OPEN, on i_timer_done: go to IDLE.
- Boundary guard: MOVE_UP at floor pFLOORS-1, or MOVE_DOWN at floor 0, never increments or wraps o_floor. The FSM goes straight to DOOR_OPEN instead (defensive; unreachable in normal operation).
- Timer handshake:
  - o_timer_en = (state != IDLE) && !restart.
  - restart is a register. It is set for exactly one cycle in the cycle after any i_timer_done is consumed, or after any entry into MOVE_*/DOOR_OPEN from another state.
  - This drives the timer count to 0 before each new period, so a single done is never counted twice.
  - i_timer_done is ignored in IDLE and while restart=1.
- Output decode (all registered state decodes): o_up = MOVE_UP, o_down = MOVE_DOWN, o_door_open = DOOR_OPEN.
- Latency:
  - A request at the current floor in IDLE gives o_door_open=1 on the next edge.
  - Each floor step takes 1 restart cycle plus one full timer period.
- Reset mid-operation: all state returns to reset values immediately. Pending requests are lost and o_timer_en drops asynchronously.

Test Plan (bench instantiates timer with pCOUNT_BITS=2, i.e. done after 3 enabled edges):
- Reset, then a 1-cycle i_req=4'b0100 at floor 0 → o_up=1 next edge. o_floor steps 0→1→2, each step 4 cycles apart. o_door_open=1 when o_floor=2, o_pending=0. After 4 further cycles the FSM is IDLE with all outputs 0 except o_floor=2.
- In IDLE at floor 2, i_req=4'b0100 → o_door_open=1 next edge, o_up=o_down=0, o_pending stays 0.
- At floor 1 after travelling up, single-cycle i_req=4'b1001 → MOVE_UP to floor 3, door open, then MOVE_DOWN to floor 0, door open. Direction preference is verified.
- During DOOR_OPEN at floor 3, hold i_req=4'b1000 for 3 cycles → request absorbed; FSM ends in IDLE with o_pending=0.
- Check o_timer_en low for exactly 1 cycle after every i_timer_done. Force i_timer_done=1 in IDLE → no state or floor change.
- Assert i_rst_n=0 mid MOVE_DOWN with o_pending=4'b0001 → o_floor=0, o_pending=0, o_timer_en=0 asynchronously, before the next clock edge.
